// File: rtl/ysyx_24080006_pkg.sv
// Shared constants and types for the ysyx_24080006 core.
// Issue-controller state encoding lives here with the register index width.
package ysyx_24080006_pkg;

  localparam int REG_WIDTH = 5;

  typedef enum logic [1:0] {
    ISSUE_RUN,
    ISSUE_FENCE,
    ISSUE_DRAIN
  } issue_state_e;

endpackage

// File: rtl/ysyx_24080006_scoreboard.sv
// Pending-write bitmap: one bit per architectural register, x0 never pending.
// Reads are combinational from the registered bitmap; updates land on the next edge.
module ysyx_24080006_scoreboard #(
  parameter int REG_WIDTH = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 set_i,
  input  logic [REG_WIDTH-1:0] set_idx_i,
  input  logic                 clr_i,
  input  logic [REG_WIDTH-1:0] clr_idx_i,
  input  logic                 clr_all_i,
  input  logic [REG_WIDTH-1:0] rs1_idx_i,
  input  logic [REG_WIDTH-1:0] rs2_idx_i,
  input  logic [REG_WIDTH-1:0] rd_idx_i,
  output logic                 rs1_pend_o,
  output logic                 rs2_pend_o,
  output logic                 rd_pend_o,
  output logic                 any_pending_o
);

  localparam int NREG = 2 ** REG_WIDTH;

  logic [NREG-1:0] pend_q, pend_d;

  // Set is applied after clear so that a same-index collision leaves the bit set.
  always_comb begin
    pend_d = pend_q;
    if (clr_all_i) begin
      pend_d = '0;
    end else begin
      if (clr_i) pend_d[clr_idx_i] = 1'b0;
      if (set_i) pend_d[set_idx_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign rs1_pend_o    = pend_q[rs1_idx_i];
  assign rs2_pend_o    = pend_q[rs2_idx_i];
  assign rd_pend_o     = pend_q[rd_idx_i];
  assign any_pending_o = |pend_q;

`ifndef SYNTHESIS
  assert property (@(posedge clock) disable iff (reset)
    !(set_i && clr_i && !clr_all_i && (set_idx_i == clr_idx_i)));
`endif

endmodule

// File: rtl/ysyx_24080006_issue_ctrl.sv
// Issue controller: holds decoded ops until RAW/WAW-safe, caps in-flight ops, sequences fence.i and post-flush drain.
// Issue handshake is combinational (0-cycle); a blocked op is simply held by decode.
module ysyx_24080006_issue_ctrl #(
  parameter int REG_WIDTH    = ysyx_24080006_pkg::REG_WIDTH,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [REG_WIDTH-1:0] id_rs1,
  input  logic [REG_WIDTH-1:0] id_rs2,
  input  logic [REG_WIDTH-1:0] id_rd,
  input  logic                 id_reg_we,
  input  logic                 id_fencei,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  input  logic                 retire,
  input  logic                 wb_we,
  input  logic [REG_WIDTH-1:0] wb_rd,
  input  logic                 flush,
  output logic                 icache_flush,
  output logic                 busy
);
  import ysyx_24080006_pkg::*;

  localparam int             CW      = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_INFLIGHT);

  issue_state_e  state_q, state_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          icache_flush_q;

  logic rs1_p, rs2_p, rd_p, any_pend;
  logic hazard, quiet, issue_ok, issue, issue_cnt, clr_all;

  assign hazard = ((id_rs1 != '0) & rs1_p) | ((id_rs2 != '0) & rs2_p) | (id_reg_we & rd_p);
  assign quiet  = (inflight_q == '0) & ~any_pend;

  assign issue_ok = (state_q == ISSUE_RUN) & ex_ready & ~flush & ~hazard
                  & (inflight_q < MAX_CNT) & (~id_fencei | quiet);
  assign issue     = ~reset & id_valid & issue_ok;
  assign issue_cnt = issue & ~id_fencei;

  assign id_ready     = issue;
  assign ex_valid     = issue;
  assign icache_flush = icache_flush_q;
  assign busy         = (inflight_q != '0) | (state_q != ISSUE_RUN);

  always_comb begin
    inflight_d = inflight_q;
    if (issue_cnt & ~retire)
      inflight_d = inflight_q + CW'(1);
    else if (~issue_cnt & retire & (inflight_q != '0))
      inflight_d = inflight_q - CW'(1);
  end

  // A flush always lands in DRAIN; a pending fence is dropped and re-fetched by the redirect.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ISSUE_RUN: begin
        if (flush)                                          state_d = ISSUE_DRAIN;
        else if (id_valid & id_fencei & ~quiet)             state_d = ISSUE_FENCE;
      end
      ISSUE_FENCE: begin
        if (flush)      state_d = ISSUE_DRAIN;
        else if (quiet) state_d = ISSUE_RUN;
      end
      ISSUE_DRAIN: begin
        if (~flush & (inflight_q == '0)) state_d = ISSUE_RUN;
      end
      default: state_d = ISSUE_RUN;
    endcase
  end

  assign clr_all = (state_q == ISSUE_DRAIN) & (state_d == ISSUE_RUN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ISSUE_RUN;
      inflight_q     <= '0;
      icache_flush_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      inflight_q     <= inflight_d;
      icache_flush_q <= issue & id_fencei;
    end
  end

  ysyx_24080006_scoreboard #(.REG_WIDTH(REG_WIDTH)) u_sb (
    .clock         (clock),
    .reset         (reset),
    .set_i         (issue & id_reg_we),
    .set_idx_i     (id_rd),
    .clr_i         (wb_we & (wb_rd != '0)),
    .clr_idx_i     (wb_rd),
    .clr_all_i     (clr_all),
    .rs1_idx_i     (id_rs1),
    .rs2_idx_i     (id_rs2),
    .rd_idx_i      (id_rd),
    .rs1_pend_o    (rs1_p),
    .rs2_pend_o    (rs2_p),
    .rd_pend_o     (rd_p),
    .any_pending_o (any_pend)
  );

`ifndef SYNTHESIS
  assert property (@(posedge clock) disable iff (reset) !(retire && (inflight_q == '0)));
  assert property (@(posedge clock) disable iff (reset) inflight_q <= MAX_CNT);
`endif

endmodule

// File: tb/tb_ysyx_24080006_issue_ctrl.sv
// Bench for the issue controller: directed hazard/cap/fence/flush/reset scenarios
// plus randomized traffic against a register-level reference model.
module tb_ysyx_24080006_issue_ctrl;
  import ysyx_24080006_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       id_valid, id_ready, id_reg_we, id_fencei;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic       ex_valid, ex_ready, retire, wb_we, flush, icache_flush, busy;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: pending set, in-flight count, mode (0 run, 1 fence, 2 drain), icache pulse.
  bit [31:0] mpend;
  int        minfl;
  int        mst;
  bit        micf;

  always #5 clock = ~clock;

  ysyx_24080006_issue_ctrl dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_we(id_reg_we), .id_fencei(id_fencei),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .retire(retire), .wb_we(wb_we), .wb_rd(wb_rd),
    .flush(flush), .icache_flush(icache_flush), .busy(busy)
  );

  function automatic bit m_ready();
    bit haz;
    haz = (id_rs1 != 0 && mpend[id_rs1]) || (id_rs2 != 0 && mpend[id_rs2]) ||
          (id_reg_we && mpend[id_rd]);
    return !reset && id_valid && mst == 0 && ex_ready && !flush && !haz && minfl < 4 &&
           (!id_fencei || (minfl == 0 && mpend == 0));
  endfunction

  function automatic bit m_busy();
    return minfl != 0 || mst != 0;
  endfunction

  task automatic model_reset();
    mpend = '0; minfl = 0; mst = 0; micf = 0;
  endtask

  // Advance model with current inputs, then step to 1 time unit after the next rising edge.
  task automatic adv();
    bit iss;
    int nst;
    iss = m_ready();
    nst = mst;
    case (mst)
      0: if (flush) nst = 2;
         else if (id_valid && id_fencei && (minfl != 0 || mpend != 0)) nst = 1;
      1: if (flush) nst = 2;
         else if (minfl == 0 && mpend == 0) nst = 0;
      default: if (!flush && minfl == 0) nst = 0;
    endcase
    if (wb_we && wb_rd != 0) mpend[wb_rd] = 1'b0;
    if (iss && id_reg_we) mpend[id_rd] = 1'b1;
    if (mst == 2 && nst == 0) mpend = '0;
    if (iss && !id_fencei && !retire) minfl++;
    else if (!(iss && !id_fencei) && retire && minfl > 0) minfl--;
    micf = iss && id_fencei;
    mst  = nst;
    @(posedge clock);
    #1;
  endtask

  task automatic op(input bit v, input int r1, input int r2, input int rd, input bit we, input bit fi);
    id_valid = v; id_rs1 = 5'(r1); id_rs2 = 5'(r2); id_rd = 5'(rd); id_reg_we = we; id_fencei = fi;
  endtask

  task automatic idle();
    op(0, 0, 0, 0, 0, 0);
    ex_ready = 1'b1; retire = 1'b0; wb_we = 1'b0; wb_rd = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    op(1, 0, 0, 3, 1, 0);
    #3;
    n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL reset_id_ready: got %b want 0", id_ready); end
    n_chk++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (icache_flush !== 1'b0) begin n_fail++; $display("FAIL reset_icache_flush: got %b want 0", icache_flush); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_raw();
    do_reset();
    op(1, 0, 0, 5, 1, 0); #3;
    n_chk++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL raw_first_issue: got %b want 1", id_ready); end
    adv();
    op(1, 5, 0, 0, 0, 0); wb_we = 1'b1; wb_rd = 5'd5; #3;
    n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_no_bypass: got %b want 0", id_ready); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL raw_busy: got %b want 1", busy); end
    adv();
    wb_we = 1'b0; #3;
    n_chk++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release: got %b want 1", id_ready); end
    adv();
  endtask

  task automatic test_waw();
    do_reset();
    op(1, 0, 0, 7, 1, 0); #3;
    n_chk++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL waw_first_issue: got %b want 1", id_ready); end
    adv();
    op(1, 0, 0, 9, 1, 0); #3;
    n_chk++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL waw_x0_sources: got %b want 1", id_ready); end
    adv();
    op(1, 0, 0, 7, 1, 0);
    for (int i = 0; i < 2; i++) begin
      #3;
      n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL waw_hold cycle %0d: got %b want 0", i, id_ready); end
      adv();
    end
    wb_we = 1'b1; wb_rd = 5'd7; #3;
    n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL waw_wb_cycle: got %b want 0", id_ready); end
    adv();
    wb_we = 1'b0; #3;
    n_chk++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL waw_release: got %b want 1", id_ready); end
    adv();
  endtask

  task automatic test_cap();
    do_reset();
    op(1, 1, 2, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #3;
      n_chk++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL cap_fill %0d: got %b want 1", i, id_ready); end
      adv();
    end
    #3;
    n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL cap_full: got %b want 0", id_ready); end
    n_chk++; if (dut.inflight_q !== 3'd4) begin n_fail++; $display("FAIL cap_count: got %0d want 4", dut.inflight_q); end
    adv();
    id_valid = 1'b0; retire = 1'b1; #3; adv();
    id_valid = 1'b1; #3;
    n_chk++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL cap_retire_issue: got %b want 1", id_ready); end
    adv();
    retire = 1'b0; #3;
    n_chk++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL cap_count_kept: got %b want 1", id_ready); end
    adv();
    #3;
    n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL cap_full_again: got %b want 0", id_ready); end
    adv();
  endtask

  task automatic test_fencei();
    do_reset();
    op(1, 0, 0, 3, 1, 0); #3; adv();
    op(1, 0, 0, 4, 1, 0); #3; adv();
    op(1, 0, 0, 0, 0, 1); #3;
    n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL fence_wait: got %b want 0", id_ready); end
    adv();
    #3;
    n_chk++; if (dut.state_q !== ISSUE_FENCE) begin n_fail++; $display("FAIL fence_state: got %0d want %0d", dut.state_q, ISSUE_FENCE); end
    retire = 1'b1; wb_we = 1'b1; wb_rd = 5'd3; adv();
    wb_rd = 5'd4; #3;
    n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL fence_draining: got %b want 0", id_ready); end
    adv();
    retire = 1'b0; wb_we = 1'b0; #3;
    n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL fence_exit_cycle: got %b want 0", id_ready); end
    adv();
    #3;
    n_chk++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL fence_issue: got %b want 1", id_ready); end
    n_chk++; if (icache_flush !== 1'b0) begin n_fail++; $display("FAIL fence_early_pulse: got %b want 0", icache_flush); end
    adv();
    idle(); #3;
    n_chk++; if (icache_flush !== 1'b1) begin n_fail++; $display("FAIL fence_pulse: got %b want 1", icache_flush); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fence_no_count: busy %b want 0", busy); end
    adv();
    #3;
    n_chk++; if (icache_flush !== 1'b0) begin n_fail++; $display("FAIL fence_pulse_width: got %b want 0", icache_flush); end
    adv();
  endtask

  task automatic test_flush();
    int waited;
    do_reset();
    for (int r = 10; r < 13; r++) begin op(1, 0, 0, r, 1, 0); #3; adv(); end
    op(1, 0, 0, 13, 1, 0); flush = 1'b1; #3;
    n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL flush_wins: got %b want 0", id_ready); end
    adv();
    flush = 1'b0; #3;
    n_chk++; if (dut.state_q !== ISSUE_DRAIN) begin n_fail++; $display("FAIL flush_state: got %0d want %0d", dut.state_q, ISSUE_DRAIN); end
    retire = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL drain_hold %0d: got %b want 0", i, id_ready); end
      adv();
    end
    retire = 1'b0; #3;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drain_last_cycle busy: got %b want 1", busy); end
    adv();
    op(1, 10, 11, 12, 1, 0); #3;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_done busy: got %b want 0", busy); end
    n_chk++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL drain_pend_cleared: got %b want 1", id_ready); end
    adv();
    op(1, 0, 0, 0, 0, 1); #3; adv();
    flush = 1'b1; #3; adv();
    flush = 1'b0; #3;
    n_chk++; if (dut.state_q !== ISSUE_DRAIN) begin n_fail++; $display("FAIL fence_flush_state: got %0d want %0d", dut.state_q, ISSUE_DRAIN); end
    retire = 1'b1; wb_we = 1'b1; wb_rd = 5'd12; adv();
    idle();
    waited = 0;
    while (busy !== 1'b0 && waited < 10) begin adv(); waited++; end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fence_flush_settle: busy %b after %0d cycles want 0", busy, waited); end
  endtask

  task automatic test_async_reset();
    do_reset();
    op(1, 0, 0, 8, 1, 0); #3; adv();
    op(1, 0, 0, 9, 1, 0); #3; adv();
    op(1, 8, 0, 0, 0, 0); flush = 1'b1; #3; adv();
    flush = 1'b0;
    reset = 1'b1; #1;
    n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready: got %b want 0", id_ready); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", busy); end
    n_chk++; if (dut.state_q !== ISSUE_RUN) begin n_fail++; $display("FAIL arst_state: got %0d want %0d", dut.state_q, ISSUE_RUN); end
    n_chk++; if (icache_flush !== 1'b0) begin n_fail++; $display("FAIL arst_icache: got %b want 0", icache_flush); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    op(1, 8, 9, 8, 1, 0); #3;
    n_chk++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL arst_first_issue: got %b want 1", id_ready); end
    adv();
  endtask

  task automatic test_random();
    bit we, fi;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      fi = ($urandom_range(0, 19) == 0);
      we = !fi && ($urandom_range(0, 1) == 1);
      op($urandom_range(0, 9) < 7, fi ? 0 : $urandom_range(0, 7), fi ? 0 : $urandom_range(0, 7),
         we ? $urandom_range(1, 7) : 0, we, fi);
      ex_ready = ($urandom_range(0, 4) != 0);
      flush    = ($urandom_range(0, 29) == 0);
      retire   = (minfl > 0) && ($urandom_range(0, 9) < 3);
      wb_we = 1'b0; wb_rd = '0;
      if (mpend != 0 && $urandom_range(0, 9) < 4) begin
        int s;
        s = $urandom_range(1, 31);
        for (int k = 0; k < 32; k++) begin
          int j;
          j = (s + k) % 32;
          if (j != 0 && mpend[j]) begin wb_we = 1'b1; wb_rd = 5'(j); break; end
        end
      end
      #3;
      n_chk++; if (id_ready !== m_ready()) begin n_fail++; $display("FAIL rand_id_ready c%0d: got %b want %b", c, id_ready, m_ready()); end
      n_chk++; if (ex_valid !== m_ready()) begin n_fail++; $display("FAIL rand_ex_valid c%0d: got %b want %b", c, ex_valid, m_ready()); end
      n_chk++; if (busy !== m_busy()) begin n_fail++; $display("FAIL rand_busy c%0d: got %b want %b", c, busy, m_busy()); end
      n_chk++; if (icache_flush !== micf) begin n_fail++; $display("FAIL rand_icache c%0d: got %b want %b", c, icache_flush, micf); end
      adv();
    end
    idle();
  endtask

  initial begin
    model_reset();
    idle();
    reset = 1'b1;
    #12;
    test_reset();
    test_raw();
    test_waw();
    test_cap();
    test_fencei();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
